// File: rtl/csr_commit_ctrl_pkg.sv
// Shared types and constants for the commit-side CSR/exception controller.
package csr_commit_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RD   = 2'd1,
        CSR_WR   = 2'd2,
        CSR_XCHG = 2'd3
    } csr_op_e;

    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    localparam int unsigned EXC_ADEF = 0;
    localparam int unsigned EXC_INE  = 1;
    localparam int unsigned EXC_SYS  = 2;
    localparam int unsigned EXC_BRK  = 3;
    localparam int unsigned EXC_ALE  = 4;

endpackage

// File: rtl/csr_commit_ctrl_excp_prio_enc.sv
// Priority encoder: interrupt, then per-instruction exception flags, then IPE.
module excp_prio_enc
    import csr_commit_pkg::*;
#(
    parameter int EXC_W = 5
) (
    input  logic             int_req,
    input  logic [EXC_W-1:0] excp,
    input  logic             ipe,
    output logic             any,
    output logic [5:0]       ecode
);

    always_comb begin
        any   = 1'b1;
        ecode = '0;
        if (int_req)                ecode = ECODE_INT;
        else if (excp[EXC_ADEF])    ecode = ECODE_ADEF;
        else if (excp[EXC_INE])     ecode = ECODE_INE;
        else if (excp[EXC_SYS])     ecode = ECODE_SYS;
        else if (excp[EXC_BRK])     ecode = ECODE_BRK;
        else if (excp[EXC_ALE])     ecode = ECODE_ALE;
        else if (ipe)               ecode = ECODE_IPE;
        else                        any   = 1'b0;
    end

endmodule

// File: rtl/csr_commit_ctrl.sv
// Commit-side CSR access / exception controller with post-flush drain.
// Optional privilege check enabled by defining CSR_PRIV_CHECK_EN.
module csr_commit_ctrl
    import csr_commit_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int EXC_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [1:0]       in_csr_op,
    input  logic [13:0]      in_csr_num,
    input  logic [31:0]      in_rd_data,
    input  logic [31:0]      in_rj_data,
    input  logic [EXC_W-1:0] in_excp,
    input  logic             in_ertn,
    input  logic             has_int,
    input  logic [31:0]      eentry,
    input  logic [31:0]      era,
    input  logic [1:0]       plv,
    output logic [13:0]      csr_raddr,
    input  logic [31:0]      csr_rdata,
    output logic             csr_wr_en,
    output logic [13:0]      csr_waddr,
    output logic [31:0]      csr_wdata,
    output logic             excp_flush,
    output logic [31:0]      era_in,
    output logic [5:0]       ecode_in,
    output logic [8:0]       esubcode_in,
    output logic             ertn_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_wen,
    output logic [31:0]      out_data
);

    state_e           state, state_nxt;
    logic [3:0]       drain_cnt;

    logic             h_valid, h_first, h_int, h_ertn;
    logic [31:0]      h_pc, h_rd, h_rj;
    csr_op_e          h_op;
    logic [13:0]      h_num;
    logic [EXC_W-1:0] h_excp;

    logic             ipe, exc_any, flush, accept;
    logic [5:0]       exc_code;

`ifdef CSR_PRIV_CHECK_EN
    assign ipe = (h_op != CSR_NONE || h_ertn) && plv != 2'd0;
`else
    logic unused_plv;
    assign unused_plv = ^plv;
    assign ipe        = 1'b0;
`endif

    excp_prio_enc #(.EXC_W(EXC_W)) u_prio (
        .int_req (h_int),
        .excp    (h_excp),
        .ipe     (ipe),
        .any     (exc_any),
        .ecode   (exc_code)
    );

    always_comb begin
        state_nxt      = state;
        csr_raddr      = '0;
        csr_wr_en      = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        excp_flush     = 1'b0;
        era_in         = '0;
        ecode_in       = '0;
        esubcode_in    = '0;
        ertn_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_valid      = 1'b0;
        out_wen        = 1'b0;
        out_data       = '0;

        if (state == DRAIN) begin
            if (drain_cnt == 4'd0) state_nxt = RUN;
        end else if (h_valid) begin
            if (exc_any) begin
                excp_flush     = 1'b1;
                era_in         = h_pc;
                ecode_in       = exc_code;
                redirect_valid = 1'b1;
                redirect_pc    = eentry;
                state_nxt      = DRAIN;
            end else if (h_ertn) begin
                ertn_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = era;
                state_nxt      = DRAIN;
            end else if (h_op != CSR_NONE) begin
                csr_raddr = h_num;
                out_valid = 1'b1;
                out_wen   = 1'b1;
                out_data  = csr_rdata;
                // Write only once per instruction, even across an out_ready stall.
                if (h_first && h_op != CSR_RD) begin
                    csr_wr_en = 1'b1;
                    csr_waddr = h_num;
                    csr_wdata = (h_op == CSR_WR) ? h_rd
                                                 : ((h_rd & h_rj) | (csr_rdata & ~h_rj));
                end
            end else begin
                out_valid = 1'b1;
            end
        end

        in_ready = (state == RUN) && (!out_valid || out_ready);
    end

    assign flush  = excp_flush | ertn_flush;
    // A younger instruction accepted alongside a flush is discarded.
    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            h_valid   <= 1'b0;
            h_first   <= 1'b0;
            h_int     <= 1'b0;
            h_ertn    <= 1'b0;
            h_pc      <= '0;
            h_rd      <= '0;
            h_rj      <= '0;
            h_op      <= CSR_NONE;
            h_num     <= '0;
            h_excp    <= '0;
        end else begin
            state <= state_nxt;
            if (flush)
                drain_cnt <= 4'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && drain_cnt != 4'd0)
                drain_cnt <= drain_cnt - 4'd1;

            if (out_valid && !out_ready) begin
                h_first <= 1'b0;
            end else if (accept) begin
                h_valid <= 1'b1;
                h_first <= 1'b1;
                h_int   <= has_int;
                h_ertn  <= in_ertn;
                h_pc    <= in_pc;
                h_rd    <= in_rd_data;
                h_rj    <= in_rj_data;
                h_op    <= csr_op_e'(in_csr_op);
                h_num   <= in_csr_num;
                h_excp  <= in_excp;
            end else begin
                h_valid <= 1'b0;
                h_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Self-checking bench: directed vector table, randomized model check, corner sequences.
module tb_csr_commit_ctrl;

    localparam int DRAIN = 3;

    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rd;
        logic [31:0] rj;
        logic [4:0]  excp;
        logic        ertn;
        logic        hint;
        logic [1:0]  plv;
        logic [31:0] pc;
        logic [31:0] eentry;
        logic [31:0] era;
        logic [31:0] rdata;
    } txn_t;

    typedef struct packed {
        logic        excp_flush;
        logic        ertn_flush;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic [31:0] era_in;
        logic [5:0]  ecode;
        logic        wr_en;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [13:0] raddr;
        logic        out_valid;
        logic        out_wen;
        logic [31:0] out_data;
    } exp_t;

    typedef struct packed {
        txn_t t;
        exp_t e;
    } vec_t;

    logic        clk = 0, reset = 0;
    logic        in_valid = 0, in_ready;
    logic [31:0] in_pc = 0, in_rd_data = 0, in_rj_data = 0;
    logic [1:0]  in_csr_op = 0, plv = 0;
    logic [13:0] in_csr_num = 0;
    logic [4:0]  in_excp = 0;
    logic        in_ertn = 0, has_int = 0;
    logic [31:0] eentry = 0, era = 0, csr_rdata = 0;
    logic [13:0] csr_raddr, csr_waddr;
    logic        csr_wr_en, excp_flush, ertn_flush, redirect_valid;
    logic [31:0] csr_wdata, era_in, redirect_pc, out_data;
    logic [5:0]  ecode_in;
    logic [8:0]  esubcode_in;
    logic        out_valid, out_ready = 1, out_wen;

    int total = 0, bad = 0;

    csr_commit_ctrl #(.DRAIN_CYCLES(DRAIN), .EXC_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_csr_op(in_csr_op), .in_csr_num(in_csr_num),
        .in_rd_data(in_rd_data), .in_rj_data(in_rj_data), .in_excp(in_excp),
        .in_ertn(in_ertn), .has_int(has_int), .eentry(eentry), .era(era), .plv(plv),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wr_en(csr_wr_en),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .excp_flush(excp_flush),
        .era_in(era_in), .ecode_in(ecode_in), .esubcode_in(esubcode_in),
        .ertn_flush(ertn_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_wen(out_wen), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: pick the highest-ranked event from the flag list, then apply its effect.
    function automatic exp_t model(input txn_t t);
        exp_t       e;
        logic [5:0] codes [5];
        logic [5:0] code;
        bit         hit;
        codes = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        e = '0;
        hit = 0;
        code = 0;
        if (t.hint) hit = 1;
        for (int i = 0; i < 5; i++)
            if (!hit && t.excp[i]) begin hit = 1; code = codes[i]; end
`ifdef CSR_PRIV_CHECK_EN
        if (!hit && (t.op != 0 || t.ertn) && t.plv != 0) begin hit = 1; code = 6'h0E; end
`endif
        if (hit) begin
            e.excp_flush = 1; e.era_in = t.pc; e.ecode = code;
            e.redirect_valid = 1; e.redirect_pc = t.eentry;
        end else if (t.ertn) begin
            e.ertn_flush = 1; e.redirect_valid = 1; e.redirect_pc = t.era;
        end else if (t.op != 0) begin
            e.raddr = t.num; e.out_valid = 1; e.out_wen = 1; e.out_data = t.rdata;
            if (t.op == 2) begin
                e.wr_en = 1; e.waddr = t.num; e.wdata = t.rd;
            end else if (t.op == 3) begin
                e.wr_en = 1; e.waddr = t.num;
                for (int b = 0; b < 32; b++) e.wdata[b] = t.rj[b] ? t.rd[b] : t.rdata[b];
            end
        end else begin
            e.out_valid = 1;
        end
        return e;
    endfunction

    task automatic drive(input txn_t t);
        in_csr_op = t.op; in_csr_num = t.num; in_rd_data = t.rd; in_rj_data = t.rj;
        in_excp = t.excp; in_ertn = t.ertn; has_int = t.hint; plv = t.plv;
        in_pc = t.pc; eentry = t.eentry; era = t.era; csr_rdata = t.rdata;
    endtask

    task automatic cmp_out(input exp_t e);
        chk("excp_flush", 32'(excp_flush), 32'(e.excp_flush));
        chk("ertn_flush", 32'(ertn_flush), 32'(e.ertn_flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.redirect_valid));
        chk("redirect_pc", redirect_pc, e.redirect_pc);
        chk("era_in", era_in, e.era_in);
        chk("ecode_in", 32'(ecode_in), 32'(e.ecode));
        chk("esubcode_in", 32'(esubcode_in), 32'd0);
        chk("csr_wr_en", 32'(csr_wr_en), 32'(e.wr_en));
        chk("csr_waddr", 32'(csr_waddr), 32'(e.waddr));
        chk("csr_wdata", csr_wdata, e.wdata);
        chk("csr_raddr", 32'(csr_raddr), 32'(e.raddr));
        chk("out_valid", 32'(out_valid), 32'(e.out_valid));
        chk("out_wen", 32'(out_wen), 32'(e.out_wen));
        chk("out_data", out_data, e.out_data);
    endtask

    task automatic run_txn(input txn_t t, input exp_t e);
        int n;
        @(negedge clk);
        drive(t);
        out_ready = 1;
        in_valid = 1;
        #1 chk("in_ready_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 0;
        has_int = 1'($urandom_range(0, 1));
        @(negedge clk);
        cmp_out(e);
        if (e.excp_flush || e.ertn_flush) begin
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("drain_len", n, DRAIN);
        end else begin
            @(negedge clk);
            chk("out_valid_clear", 32'(out_valid), 32'd0);
        end
    endtask

    vec_t vecs [10];
    txn_t base, t;
    exp_t z, e;
    int   pulses;

    initial begin
        base = '0;
        base.pc = 32'h1C00_0000; base.eentry = 32'h1C00_8000; base.era = 32'h1C00_0400;
        z = '0;

        // csrwr
        vecs[0].t = base; vecs[0].t.op = 2; vecs[0].t.num = 14'h30;
        vecs[0].t.rd = 32'hDEADBEEF; vecs[0].t.rdata = 32'h12345678;
        vecs[0].e = z; vecs[0].e.wr_en = 1; vecs[0].e.waddr = 14'h30; vecs[0].e.wdata = 32'hDEADBEEF;
        vecs[0].e.raddr = 14'h30; vecs[0].e.out_valid = 1; vecs[0].e.out_wen = 1;
        vecs[0].e.out_data = 32'h12345678;
        // csrxchg: (FFFF0000&00FF00FF)|(0000FFFF&FF00FF00)
        vecs[1].t = base; vecs[1].t.op = 3; vecs[1].t.num = 14'h05; vecs[1].t.rd = 32'hFFFF0000;
        vecs[1].t.rj = 32'h00FF00FF; vecs[1].t.rdata = 32'h0000FFFF;
        vecs[1].e = z; vecs[1].e.wr_en = 1; vecs[1].e.waddr = 14'h05; vecs[1].e.wdata = 32'h00FFFF00;
        vecs[1].e.raddr = 14'h05; vecs[1].e.out_valid = 1; vecs[1].e.out_wen = 1;
        vecs[1].e.out_data = 32'h0000FFFF;
        // SYS on a csrwr: write suppressed
        vecs[2].t = base; vecs[2].t.op = 2; vecs[2].t.num = 14'h30; vecs[2].t.excp = 5'b00100;
        vecs[2].t.pc = 32'h1C000100; vecs[2].t.eentry = 32'h1C008000;
        vecs[2].e = z; vecs[2].e.excp_flush = 1; vecs[2].e.era_in = 32'h1C000100; vecs[2].e.ecode = 6'h0B;
        vecs[2].e.redirect_valid = 1; vecs[2].e.redirect_pc = 32'h1C008000;
        // interrupt beats BRK
        vecs[3].t = base; vecs[3].t.hint = 1; vecs[3].t.excp = 5'b01000;
        vecs[3].e = z; vecs[3].e.excp_flush = 1; vecs[3].e.era_in = base.pc; vecs[3].e.ecode = 6'h00;
        vecs[3].e.redirect_valid = 1; vecs[3].e.redirect_pc = base.eentry;
        // ertn
        vecs[4].t = base; vecs[4].t.ertn = 1; vecs[4].t.era = 32'h1C000200;
        vecs[4].e = z; vecs[4].e.ertn_flush = 1; vecs[4].e.redirect_valid = 1;
        vecs[4].e.redirect_pc = 32'h1C000200;
        // csrrd
        vecs[5].t = base; vecs[5].t.op = 1; vecs[5].t.num = 14'h3FFF; vecs[5].t.rd = 32'h1;
        vecs[5].t.rdata = 32'hCAFEF00D;
        vecs[5].e = z; vecs[5].e.raddr = 14'h3FFF; vecs[5].e.out_valid = 1; vecs[5].e.out_wen = 1;
        vecs[5].e.out_data = 32'hCAFEF00D;
        // plain instruction
        vecs[6].t = base; vecs[6].t.rdata = 32'h55555555;
        vecs[6].e = z; vecs[6].e.out_valid = 1;
        // ADEF beats ALE
        vecs[7].t = base; vecs[7].t.excp = 5'b10001;
        vecs[7].e = z; vecs[7].e.excp_flush = 1; vecs[7].e.era_in = base.pc; vecs[7].e.ecode = 6'h08;
        vecs[7].e.redirect_valid = 1; vecs[7].e.redirect_pc = base.eentry;
        // INE beats SYS
        vecs[8].t = base; vecs[8].t.excp = 5'b00110;
        vecs[8].e = z; vecs[8].e.excp_flush = 1; vecs[8].e.era_in = base.pc; vecs[8].e.ecode = 6'h0D;
        vecs[8].e.redirect_valid = 1; vecs[8].e.redirect_pc = base.eentry;
        // ALE beats ertn
        vecs[9].t = base; vecs[9].t.excp = 5'b10000; vecs[9].t.ertn = 1;
        vecs[9].e = z; vecs[9].e.excp_flush = 1; vecs[9].e.era_in = base.pc; vecs[9].e.ecode = 6'h09;
        vecs[9].e.redirect_valid = 1; vecs[9].e.redirect_pc = base.eentry;

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_out(z);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i].t, vecs[i].e);

        // out_ready stall after csrwr
        @(negedge clk);
        t = base; t.op = 2; t.num = 14'h40; t.rd = 32'hA5A5A5A5; t.rdata = 32'h0F0F0F0F;
        drive(t);
        out_ready = 0; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        pulses = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            pulses += int'(csr_wr_en);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_data", out_data, 32'h0F0F0F0F);
        end
        out_ready = 1;
        #1 chk("handshake_in_ready", 32'(in_ready), 32'd1);
        pulses += int'(csr_wr_en);
        @(negedge clk);
        pulses += int'(csr_wr_en);
        chk("stall_released", 32'(out_valid), 32'd0);
        chk("stall_wr_pulses", pulses, 1);

        // back-to-back csr ops
        @(negedge clk);
        t = base; t.op = 2; t.num = 14'h11; t.rd = 32'h11111111;
        drive(t); in_valid = 1;
        @(posedge clk);
        #1 t = base; t.op = 3; t.num = 14'h22; t.rd = 32'hFFFFFFFF; t.rj = 32'h0000FFFF;
        t.rdata = 32'h12340000;
        drive(t);
        @(negedge clk);
        chk("b2b_wr1", 32'(csr_wr_en), 32'd1);
        chk("b2b_addr1", 32'(csr_waddr), 32'h11);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        e = model(t);
        chk("b2b_wr2", 32'(csr_wr_en), 32'd1);
        chk("b2b_addr2", 32'(csr_waddr), 32'h22);
        chk("b2b_data2", csr_wdata, e.wdata);

        // reset while draining
        @(negedge clk);
        t = base; t.excp = 5'b00100;
        drive(t); in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("rst_pre_flush", 32'(excp_flush), 32'd1);
        @(negedge clk);
        chk("rst_in_drain", 32'(in_ready), 32'd0);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_no_flush", 32'(excp_flush | ertn_flush | redirect_valid), 32'd0);
        @(negedge clk);
        chk("rst_ready2", 32'(in_ready), 32'd1);

        // randomized against the reference model
        for (int i = 0; i < 200; i++) begin
            t.op = 2'($urandom_range(0, 3));
            t.num = 14'($urandom);
            t.rd = $urandom; t.rj = $urandom; t.rdata = $urandom;
            t.excp = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            t.ertn = ($urandom_range(0, 7) == 0);
            t.hint = ($urandom_range(0, 7) == 0);
            t.plv = 2'($urandom_range(0, 3));
            t.pc = $urandom; t.eentry = $urandom; t.era = $urandom;
            run_txn(t, model(t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
